pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline-stage register and successor to the fixed ID/EX latch. It carries a control bundle and a data bundle between two stages using a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready. It adds synchronous flush and bubble suppression, which forces control to zero whenever the output is invalid, plus a saturating stall counter. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
CTRL_W, 8, width of the control bundle (AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, AluOp[1:0], spare)
DATA_W, 217, width of the data bundle (rs1Data 64 + rs2Data 64 + rs/rt/rd 15 + immediate 64 + spare 10)
STALL_CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous squash of all held entries
stall_clr  in  1  synchronous clear of stall_cnt
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept (registered)
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control bundle; all-zero when out_valid=0
out_data  out  DATA_W  data bundle of the main entry
stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async, rst=1): state=EMPTY; out_valid=0; in_ready=1; out_ctrl=0; out_data=0; skid registers=0; stall_cnt=0. Any entries in flight are discarded.
- Definitions: acc = in_valid & in_ready; drn = out_valid & out_ready.
- Registers: main entry (ctrl+data), skid entry (ctrl+data), 2-bit state.
- States:
  - EMPTY (out_valid=0, in_ready=1)
  - FULL (out_valid=1, in_ready=1)
  - SKID (out_valid=1, in_ready=0)
- EMPTY: acc -> FULL, main<=in. Otherwise stay.
- FULL:
  - acc & !drn -> SKID, skid<=in.
  - acc & drn -> FULL, main<=in.
  - !acc & drn -> EMPTY.
  - Otherwise hold.
- SKID: drn -> FULL, main<=skid. Otherwise hold. acc is impossible because in_ready=0.
- flush has priority over all transitions. Next state is EMPTY and any same-cycle acc is dropped, although in_ready may read 1 that cycle. Data registers may keep stale values.
- out_ctrl = out_valid ? main_ctrl : 0, combinational masking. This makes every bubble a NOP (no RegWrite/MemWrite).
- out_data is not masked.
- in_ready = (state != SKID), decoded from the registered state. No combinational path from out_ready.
- Latency: 1 cycle input->output when EMPTY. Sustained throughput 1 entry/cycle. Strict FIFO order; no entry duplicated or lost except by flush or rst.
- stall_cnt: +1 each cycle out_valid & !out_ready. Saturates at 2^STALL_CNT_W-1 and does not wrap. stall_clr has priority over increment. flush does not clear it.
- No X on outputs after reset. Widths are exact; no truncation between in_* and out_*.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t
  - ctrl bit-index localparams (CTRL_ALUSRC=0 … CTRL_ALUOP lsb=5)
  - default width constants
- Sub-module pipe_stall_counter: saturating counter with clr/inc, parametrised by width.

Test Plan:
- Reset then in_valid=1, ctrl=8'h1F, data=A, out_ready=1 -> out_valid=1, out_ctrl=8'h1F, out_data=A one cycle later; in_ready stays 1.
- Back-to-back stream of 10 entries with out_ready=1 -> 10 outputs on consecutive cycles, in order, stall_cnt=0.
- FULL with A; drop out_ready; push B -> state SKID, in_ready=0, stall_cnt increments. Raise out_ready -> A then B on consecutive cycles; in_ready=1 again.
- SKID state with flush=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, and C is never emitted.
- STALL_CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_cnt=15. Pulse stall_clr -> 0.
- Assert rst mid-stream in SKID state -> immediately out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for elastic pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  // Control bundle bit positions
  localparam int CTRL_ALUSRC    = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_REGWRITE  = 2;
  localparam int CTRL_MEMREAD   = 3;
  localparam int CTRL_MEMWRITE  = 4;
  localparam int CTRL_ALUOP_LSB = 5;
  localparam int CTRL_ALUOP_MSB = 6;
  localparam int CTRL_SPARE     = 7;

  localparam int DEF_CTRL_W      = 8;
  localparam int DEF_DATA_W      = 217;
  localparam int DEF_STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible the cycle after the event. No backpressure.
module pipe_stall_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: main + skid entry, registered in_ready, flush, bubble-masked ctrl.
// Latency 1 cycle when empty; 1 entry/cycle sustained; in_ready drops only when both entries held.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = DEF_CTRL_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall_clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t       state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              acc, drn;
  logic              ld_main_in, ld_main_skid, ld_skid;

  // Handshake outputs come straight from the state register, never from out_ready.
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_SKID);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nxt  = ST_FULL;
          ld_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (acc && !drn) begin
          state_nxt = ST_SKID;
          ld_skid   = 1'b1;
        end else if (acc && drn) begin
          ld_main_in = 1'b1;
        end else if (drn) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (drn) begin
          state_nxt    = ST_FULL;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush squashes everything, including a same-cycle accept.
    if (flush) begin
      state_nxt    = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state <= state_nxt;
      if (ld_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (ld_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (ld_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  // Bubbles present an all-zero control word so they behave as NOPs downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;

  pipe_stall_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stall_clr),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue model of the held entries plus directed literal checks.
module tb_pipe_skid_reg;

  localparam int CW = 8;
  localparam int DW = 217;
  typedef logic [CW+DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          stall_clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;

  logic          in_ready4, out_valid4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [3:0]    stall_cnt4;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_clr(stall_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .stall_clr(stall_clr),
    .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
    .stall_cnt(stall_cnt4)
  );

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  ent_t q[$];
  int   scnt = 0;
  bit   m_vld, m_rdy;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [223:0] w;
    for (int k = 0; k < 7; k++) w[k*32 +: 32] = $urandom;
    return w[DW-1:0];
  endfunction

  // Model: the stage is a FIFO of depth 2; ready while it has room, valid while non-empty.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      scnt = 0;
    end else begin
      m_vld = (q.size() > 0);
      m_rdy = (q.size() < 2);
      if (stall_clr) scnt = 0;
      else if (m_vld && !out_ready) scnt++;
      if (flush) q.delete();
      else begin
        if (m_vld && out_ready) void'(q.pop_front());
        if (in_valid && m_rdy) q.push_back({in_ctrl, in_data});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m_valid", out_valid, q.size() > 0);
      chk("m_ready", in_ready, q.size() < 2);
      chk("m_ctrl", out_ctrl, (q.size() > 0) ? q[0][CW+DW-1:DW] : '0);
      if (q.size() > 0) chk("m_data", out_data, q[0][DW-1:0]);
      chk("m_stall16", stall_cnt, (scnt > 65535) ? 65535 : scnt);
      chk("m4_valid", out_valid4, q.size() > 0);
      chk("m4_ready", in_ready4, q.size() < 2);
      chk("m4_ctrl", out_ctrl4, (q.size() > 0) ? q[0][CW+DW-1:DW] : '0);
      if (q.size() > 0) chk("m4_data", out_data4, q[0][DW-1:0]);
      chk("m4_stall", stall_cnt4, (scnt > 15) ? 15 : scnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    logic [DW-1:0] da, db;
    da = rnd_data();
    db = rnd_data();

    #1 rst = 1'b1;
    repeat (2) cyc();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_ctrl", out_ctrl, 8'h00);
    chk("rst_data", out_data, '0);
    chk("rst_stall", stall_cnt, 16'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single entry, one cycle latency
    out_ready = 1'b1;
    push(8'h1F, da);
    cyc();
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_ctrl", out_ctrl, 8'h1F);
    chk("t1_data", out_data, da);
    chk("t1_ready", in_ready, 1'b1);

    // Back-to-back stream
    for (int i = 0; i < 10; i++) begin
      push(CW'(i + 1), DW'(100 + i));
      cyc();
      chk("t2_valid", out_valid, 1'b1);
      chk("t2_data", out_data, DW'(100 + i));
      chk("t2_ctrl", out_ctrl, CW'(i + 1));
    end
    in_valid = 1'b0;
    cyc();
    chk("t2_empty", out_valid, 1'b0);
    chk("t2_stall", stall_cnt, 16'd0);

    // Fill into skid, then drain in order
    out_ready = 1'b0;
    push(8'h05, da);
    cyc();
    chk("t3_full_ready", in_ready, 1'b1);
    push(8'h0A, db);
    cyc();
    in_valid = 1'b0;
    chk("t3_skid_ready", in_ready, 1'b0);
    chk("t3_skid_data", out_data, da);
    chk("t3_stall1", stall_cnt, 16'd1);
    cyc();
    chk("t3_stall2", stall_cnt, 16'd2);
    out_ready = 1'b1;
    cyc();
    chk("t3_b_data", out_data, db);
    chk("t3_b_ctrl", out_ctrl, 8'h0A);
    chk("t3_ready_back", in_ready, 1'b1);
    cyc();
    chk("t3_drained", out_valid, 1'b0);

    // Flush while in skid with a concurrent push
    out_ready = 1'b0;
    push(8'h11, rnd_data());
    cyc();
    push(8'h12, rnd_data());
    cyc();
    push(8'h13, rnd_data());
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_ctrl", out_ctrl, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_no_c", out_valid, 1'b0);
    end

    // Saturation of the narrow counter
    out_ready = 1'b0;
    push(8'h21, rnd_data());
    cyc();
    in_valid = 1'b0;
    stall_clr = 1'b1;
    cyc();
    stall_clr = 1'b0;
    repeat (20) cyc();
    chk("t5_sat4", stall_cnt4, 4'd15);
    chk("t5_cnt16", stall_cnt, 16'd20);
    stall_clr = 1'b1;
    cyc();
    stall_clr = 1'b0;
    chk("t5_clr4", stall_cnt4, 4'd0);
    chk("t5_clr16", stall_cnt, 16'd0);
    out_ready = 1'b1;
    cyc();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 7 : 3));
      flush     = ($urandom_range(0, 49) == 0);
      stall_clr = ($urandom_range(0, 49) == 0);
      in_ctrl   = CW'($urandom);
      in_data   = rnd_data();
      cyc();
    end
    flush = 1'b0;
    stall_clr = 1'b0;
    in_valid = 1'b0;

    // Async reset while in skid
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    out_ready = 1'b0;
    push(8'h31, rnd_data());
    cyc();
    push(8'h32, rnd_data());
    cyc();
    in_valid = 1'b0;
    chk("t7_in_skid", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t7_valid", out_valid, 1'b0);
    chk("t7_ready", in_ready, 1'b1);
    chk("t7_ctrl", out_ctrl, 8'h00);
    chk("t7_stall", stall_cnt, 16'd0);
    chk("t7_stall4", stall_cnt4, 4'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t7_after", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
